// File: rtl/tx_pulse_seq.sv
// -----------------------------------------------------------------------------
// tx_pulse_seq
//
// Transmit pulse sequencer in the ref_clk domain. A rising edge on trig starts
// one pulse. The sequencer keys the power amplifier, waits a pre-guard
// interval, and then steps the DAC waveform-buffer read address from 0 to
// len-1, one address per cycle. It holds the PA through a post-guard interval
// and then returns to idle.
//
// Build option:
//   TX_PA_GUARD_EN  defined   -> PRE and POST guard states are present.
//                   undefined -> an accepted edge goes straight to ACTIVE,
//                                pa_en follows tx_active, and the guard
//                                parameters do not affect behaviour.
//
// Parameters:
//   ADDR_W      width of txsmps / tx_addr (the buffer holds 2^ADDR_W samples)
//   PRE_GUARD   cycles pa_en is high before the first sample (1..65535)
//   POST_GUARD  cycles pa_en stays high after the last sample (1..65535)
//
// Ports:
//   clk         fabric reference clock
//   rst         synchronous active-high reset
//   trig        start request; its rising edge is the event
//   txsmps      samples per pulse, latched on acceptance (0 means 2^ADDR_W)
//   tx_addr     registered DAC buffer read address
//   tx_active   high while tx_addr presents valid samples
//   pa_en       power-amplifier enable
//   busy        high whenever the sequencer is not idle
//   done        one-cycle pulse on the first idle cycle after a pulse
//   missed_cnt  saturating count of trigger edges ignored while busy
// -----------------------------------------------------------------------------
module tx_pulse_seq #(
    parameter int ADDR_W     = 14,
    parameter int PRE_GUARD  = 64,
    parameter int POST_GUARD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [ADDR_W-1:0] txsmps,
    output logic [ADDR_W-1:0] tx_addr,
    output logic              tx_active,
    output logic              pa_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       missed_cnt
);

`ifdef TX_PA_GUARD_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_POST   = 2'd3
    } state_t;

    // Terminal values of the guard counter; it counts 0..GUARD-1.
    localparam logic [15:0] PRE_LAST_C  = 16'(PRE_GUARD - 1);
    localparam logic [15:0] POST_LAST_C = 16'(POST_GUARD - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd2
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE_C = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};

    // Guard lengths outside 1..65535 do not fit the 16-bit guard counter.
    generate
        if ((PRE_GUARD < 1) || (PRE_GUARD > 65535) ||
            (POST_GUARD < 1) || (POST_GUARD > 65535)) begin : g_guard_range_err
            $error("tx_pulse_seq: PRE_GUARD/POST_GUARD must be in 1..65535");
        end
    endgenerate

    // A programmed count of 0 selects a full buffer, so len needs one extra bit.
    function automatic logic [ADDR_W:0] len_from_txsmps(input logic [ADDR_W-1:0] smps);
        logic [ADDR_W:0] len_v;
        if (smps == {ADDR_W{1'b0}}) begin
            len_v = {1'b1, {ADDR_W{1'b0}}};
        end else begin
            len_v = {1'b0, smps};
        end
        return len_v;
    endfunction

    state_t          state_r;
    logic            trig_d_r;
    logic [ADDR_W:0] len_r;
`ifdef TX_PA_GUARD_EN
    logic [15:0]     guard_cnt_r;
`endif

    logic edge_s;
    logic addr_last_s;
    logic miss_s;

    assign edge_s      = trig & ~trig_d_r;
    // The address counter stops at len-1, so it never wraps, even for a full buffer.
    assign addr_last_s = ({1'b0, tx_addr} == (len_r - LEN_ONE_C));
    assign miss_s      = edge_s && (state_r != ST_IDLE) && (missed_cnt != 16'hFFFF);

    // Sequencer state, trigger edge detector and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            trig_d_r    <= 1'b1;  // a trig held high through reset is not an edge
            len_r       <= {(ADDR_W+1){1'b0}};
`ifdef TX_PA_GUARD_EN
            guard_cnt_r <= 16'd0;
`endif
            tx_addr     <= {ADDR_W{1'b0}};
            tx_active   <= 1'b0;
            pa_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            missed_cnt  <= 16'd0;
        end else begin
            trig_d_r <= trig;
            done     <= 1'b0;

            if (miss_s) begin
                missed_cnt <= missed_cnt + 16'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        len_r <= len_from_txsmps(txsmps);
                        busy  <= 1'b1;
                        pa_en <= 1'b1;
`ifdef TX_PA_GUARD_EN
                        state_r     <= ST_PRE;
                        guard_cnt_r <= 16'd0;
`else
                        state_r   <= ST_ACTIVE;
                        tx_addr   <= {ADDR_W{1'b0}};
                        tx_active <= 1'b1;
`endif
                    end
                end

`ifdef TX_PA_GUARD_EN
                ST_PRE: begin
                    if (guard_cnt_r == PRE_LAST_C) begin
                        state_r   <= ST_ACTIVE;
                        tx_addr   <= {ADDR_W{1'b0}};
                        tx_active <= 1'b1;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 16'd1;
                    end
                end
`endif

                ST_ACTIVE: begin
                    if (addr_last_s) begin
                        tx_addr   <= {ADDR_W{1'b0}};
                        tx_active <= 1'b0;
`ifdef TX_PA_GUARD_EN
                        state_r     <= ST_POST;
                        guard_cnt_r <= 16'd0;
`else
                        state_r <= ST_IDLE;
                        pa_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        tx_addr <= tx_addr + ADDR_ONE_C;
                    end
                end

`ifdef TX_PA_GUARD_EN
                ST_POST: begin
                    if (guard_cnt_r == POST_LAST_C) begin
                        state_r <= ST_IDLE;
                        pa_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 16'd1;
                    end
                end
`endif

                default: begin
                    // Unreachable encoding: drop back to a quiet idle.
                    state_r   <= ST_IDLE;
                    tx_addr   <= {ADDR_W{1'b0}};
                    tx_active <= 1'b0;
                    pa_en     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pulse_seq.sv
// -----------------------------------------------------------------------------
// tb_tx_pulse_seq
//
// Self-checking bench for tx_pulse_seq with ADDR_W=4, PRE_GUARD=4 and
// POST_GUARD=2. The expected timing uses effective guard lengths: 4/2 when
// TX_PA_GUARD_EN is defined and 0/0 otherwise. Expected read addresses are
// queued when a trigger is driven. They are compared with the addresses the
// DUT presents while tx_active is high.
// -----------------------------------------------------------------------------
module tb_tx_pulse_seq;

    localparam int ADDR_W = 4;
    localparam int PG     = 4;
    localparam int QG     = 2;
`ifdef TX_PA_GUARD_EN
    localparam int P_EFF = PG;
    localparam int Q_EFF = QG;
`else
    localparam int P_EFF = 0;
    localparam int Q_EFF = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trig = 1'b0;
    logic [ADDR_W-1:0] txsmps = 4'd0;
    logic [ADDR_W-1:0] tx_addr;
    logic              tx_active;
    logic              pa_en;
    logic              busy;
    logic              done;
    logic [15:0]       missed_cnt;

    tx_pulse_seq #(
        .ADDR_W    (ADDR_W),
        .PRE_GUARD (PG),
        .POST_GUARD(QG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .txsmps    (txsmps),
        .tx_addr   (tx_addr),
        .tx_active (tx_active),
        .pa_en     (pa_en),
        .busy      (busy),
        .done      (done),
        .missed_cnt(missed_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int exp_q[$];
    int got_q[$];

    typedef struct {
        int addr;
        bit act;
        bit pa;
        bit bsy;
        bit dn;
        int miss;
    } obs_t;
    obs_t obs [0:127];

    int pa_cnt, act_cnt, done_cnt, first_pa, last_pa, first_act, done_i;
    int busy_ne_pa, pa_only, addr_nz;

    // Collects observations for n cycles. The posedge right after the call
    // samples trig_pat[0]/rst_pat[0]. Sample i is taken at the i-th negedge,
    // and the pattern bit i is then driven for the next posedge.
    task automatic watch(input int n, input logic [63:0] trig_pat, input logic [63:0] rst_pat);
        pa_cnt = 0; act_cnt = 0; done_cnt = 0; first_pa = 0; last_pa = 0;
        first_act = 0; done_i = 0; busy_ne_pa = 0; pa_only = 0; addr_nz = 0;
        got_q.delete();
        trig = trig_pat[0];
        rst  = rst_pat[0];
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            obs[i] = '{int'(tx_addr), tx_active, pa_en, busy, done, int'(missed_cnt)};
            if (pa_en) begin
                pa_cnt++;
                if (first_pa == 0) first_pa = i;
                last_pa = i;
            end
            if (tx_active) begin
                act_cnt++;
                if (first_act == 0) first_act = i;
                got_q.push_back(int'(tx_addr));
            end else if (tx_addr != 4'd0) begin
                addr_nz++;
            end
            if (pa_en && !tx_active) pa_only++;
            if (busy != pa_en) busy_ne_pa++;
            if (done) begin
                done_cnt++;
                done_i = i;
            end
            trig = (i < 64) ? trig_pat[i] : trig_pat[63];
            rst  = (i < 64) ? rst_pat[i] : 1'b0;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        trig = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        trig   = 1'b1;
        txsmps = 4'd5;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_addr !== 4'd0) begin n_fails++; $display("FAIL reset_tx_addr: got %0d expected 0", tx_addr); end
        n_checks++; if (tx_active !== 1'b0) begin n_fails++; $display("FAIL reset_tx_active: got %0b expected 0", tx_active); end
        n_checks++; if (pa_en !== 1'b0) begin n_fails++; $display("FAIL reset_pa_en: got %0b expected 0", pa_en); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (missed_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_missed: got %0d expected 0", missed_cnt); end
        rst  = 1'b0;
        trig = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pulse();
        int len = 5;
        int e, g;
        do_reset();
        txsmps = 4'd5;
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back(a);
        fork
            watch(P_EFF + len + Q_EFF + 6, 64'h1, 64'h0);
            begin
                @(negedge clk);
                txsmps = 4'd2;  // must not affect the accepted pulse
            end
        join
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL single_addr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g != e) begin n_fails++; $display("FAIL single_addr: got %0d expected %0d", g, e); end
        end
        n_checks++; if (pa_cnt != P_EFF + len + Q_EFF) begin n_fails++; $display("FAIL single_pa_len: got %0d expected %0d", pa_cnt, P_EFF + len + Q_EFF); end
        n_checks++; if (first_pa != 1) begin n_fails++; $display("FAIL single_pa_start: got %0d expected 1", first_pa); end
        n_checks++; if (last_pa - first_pa + 1 != pa_cnt) begin n_fails++; $display("FAIL single_pa_contig: got span %0d expected %0d", last_pa - first_pa + 1, pa_cnt); end
        n_checks++; if (first_act != P_EFF + 1) begin n_fails++; $display("FAIL single_act_start: got %0d expected %0d", first_act, P_EFF + 1); end
        n_checks++; if (act_cnt != len) begin n_fails++; $display("FAIL single_act_len: got %0d expected %0d", act_cnt, len); end
        n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_i != P_EFF + len + Q_EFF + 1) begin n_fails++; $display("FAIL single_done_time: got %0d expected %0d", done_i, P_EFF + len + Q_EFF + 1); end
        n_checks++; if (busy_ne_pa != 0) begin n_fails++; $display("FAIL single_busy_vs_pa: got %0d differing cycles expected 0", busy_ne_pa); end
        n_checks++; if (pa_only != P_EFF + Q_EFF) begin n_fails++; $display("FAIL single_guard_cycles: got %0d expected %0d", pa_only, P_EFF + Q_EFF); end
        n_checks++; if (addr_nz != 0) begin n_fails++; $display("FAIL single_idle_addr: got %0d nonzero cycles expected 0", addr_nz); end
        n_checks++; if (missed_cnt !== 16'd0) begin n_fails++; $display("FAIL single_missed: got %0d expected 0", missed_cnt); end
    endtask

    task automatic test_missed();
        int len = 8;
        int e, g;
        logic [63:0] pat;
        do_reset();
        txsmps = 4'd8;
        pat = 64'h1;
        pat[P_EFF + 2] = 1'b1;
        pat[P_EFF + 4] = 1'b1;
        pat[P_EFF + 6] = 1'b1;
        pat[P_EFF + len + Q_EFF] = 1'b1;  // sampled on the edge that returns to idle
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back(a);
        watch(P_EFF + len + Q_EFF + 10, pat, 64'h0);
        trig = 1'b0;
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL missed_addr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g != e) begin n_fails++; $display("FAIL missed_addr: got %0d expected %0d", g, e); end
        end
        n_checks++; if (missed_cnt !== 16'd4) begin n_fails++; $display("FAIL missed_count: got %0d expected 4", missed_cnt); end
        n_checks++; if (pa_cnt != P_EFF + len + Q_EFF) begin n_fails++; $display("FAIL missed_no_second_pulse: got %0d pa cycles expected %0d", pa_cnt, P_EFF + len + Q_EFF); end
        n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL missed_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_len_zero();
        int len = 16;
        int e, g;
        do_reset();
        txsmps = 4'd0;
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back(a);
        watch(P_EFF + len + Q_EFF + 4, 64'h1, 64'h0);
        n_checks++; if (act_cnt != len) begin n_fails++; $display("FAIL full_act_len: got %0d expected %0d", act_cnt, len); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL full_addr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g != e) begin n_fails++; $display("FAIL full_addr: got %0d expected %0d", g, e); end
        end
        n_checks++; if (obs[P_EFF + len + 1].act != 1'b0) begin n_fails++; $display("FAIL full_act_end: got %0b expected 0", obs[P_EFF + len + 1].act); end
        n_checks++; if (pa_cnt != P_EFF + len + Q_EFF) begin n_fails++; $display("FAIL full_pa_len: got %0d expected %0d", pa_cnt, P_EFF + len + Q_EFF); end
    endtask

    task automatic test_trig_held();
        int len = 3;
        int e, g;
        rst  = 1'b1;
        trig = 1'b1;
        repeat (2) @(negedge clk);
        watch(20, {64{1'b1}}, 64'h0);
        n_checks++; if (pa_cnt != 0) begin n_fails++; $display("FAIL held_no_pulse: got %0d pa cycles expected 0", pa_cnt); end
        n_checks++; if (obs[20].miss != 0) begin n_fails++; $display("FAIL held_missed: got %0d expected 0", obs[20].miss); end
        trig = 1'b0;
        txsmps = 4'd3;
        @(negedge clk);
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back(a);
        watch(P_EFF + len + Q_EFF + 6, 64'h1, 64'h0);
        trig = 1'b0;
        n_checks++; if (pa_cnt != P_EFF + len + Q_EFF) begin n_fails++; $display("FAIL held_pulse_len: got %0d expected %0d", pa_cnt, P_EFF + len + Q_EFF); end
        n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL held_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL held_addr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g != e) begin n_fails++; $display("FAIL held_addr: got %0d expected %0d", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int len = 7;
        int e, g;
        logic [63:0] tpat;
        logic [63:0] rpat;
        do_reset();
        txsmps = 4'd7;
        tpat = 64'h1;
        tpat[P_EFF + 2] = 1'b1;  // one ignored edge so the reset must clear missed_cnt
        rpat = 64'h0;
        rpat[P_EFF + 4] = 1'b1;  // reset sampled while tx_addr is 3
        exp_q.delete();
        for (int a = 0; a < 4; a++) exp_q.push_back(a);
        watch(P_EFF + 12, tpat, rpat);
        trig = 1'b0;
        n_checks++; if (obs[P_EFF + 4].addr != 3) begin n_fails++; $display("FAIL rmid_addr_before: got %0d expected 3", obs[P_EFF + 4].addr); end
        n_checks++; if (obs[P_EFF + 4].miss != 1) begin n_fails++; $display("FAIL rmid_missed_before: got %0d expected 1", obs[P_EFF + 4].miss); end
        n_checks++; if (obs[P_EFF + 5].addr != 0) begin n_fails++; $display("FAIL rmid_addr_after: got %0d expected 0", obs[P_EFF + 5].addr); end
        n_checks++; if (obs[P_EFF + 5].act != 1'b0) begin n_fails++; $display("FAIL rmid_act_after: got %0b expected 0", obs[P_EFF + 5].act); end
        n_checks++; if (obs[P_EFF + 5].pa != 1'b0) begin n_fails++; $display("FAIL rmid_pa_after: got %0b expected 0", obs[P_EFF + 5].pa); end
        n_checks++; if (obs[P_EFF + 5].bsy != 1'b0) begin n_fails++; $display("FAIL rmid_busy_after: got %0b expected 0", obs[P_EFF + 5].bsy); end
        n_checks++; if (obs[P_EFF + 5].miss != 0) begin n_fails++; $display("FAIL rmid_missed_after: got %0d expected 0", obs[P_EFF + 5].miss); end
        n_checks++; if (done_cnt != 0) begin n_fails++; $display("FAIL rmid_no_done: got %0d expected 0", done_cnt); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL rmid_addr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g != e) begin n_fails++; $display("FAIL rmid_addr: got %0d expected %0d", g, e); end
        end
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back(a);
        watch(P_EFF + len + Q_EFF + 4, 64'h1, 64'h0);
        trig = 1'b0;
        n_checks++; if (act_cnt != len) begin n_fails++; $display("FAIL rmid_new_act_len: got %0d expected %0d", act_cnt, len); end
        n_checks++; if (pa_cnt != P_EFF + len + Q_EFF) begin n_fails++; $display("FAIL rmid_new_pa_len: got %0d expected %0d", pa_cnt, P_EFF + len + Q_EFF); end
        n_checks++; if (done_cnt != 1) begin n_fails++; $display("FAIL rmid_new_done: got %0d expected 1", done_cnt); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g != e) begin n_fails++; $display("FAIL rmid_new_addr: got %0d expected %0d", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_missed();
        test_len_zero();
        test_trig_held();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
